// File: rtl/ccd_conv3x3_stream_filter_if.sv
// Pixel stream bundle for the CCD 3x3 filter.
// Master drives pixels in, slave returns filtered pixels.
interface ccd_conv3x3_stream_filter_if #(
  parameter int DW = 30
);
  logic          iDVAL;
  logic [DW-1:0] iDATA;
  logic [1:0]    iMODE;
  logic          oREADY;
  logic          oDVAL;
  logic [DW-1:0] oDATA;
  logic          oFRAME_DONE;

  modport master (
    output iDVAL, iDATA, iMODE,
    input  oREADY, oDVAL, oDATA, oFRAME_DONE
  );

  modport slave (
    input  iDVAL, iDATA, iMODE,
    output oREADY, oDVAL, oDATA, oFRAME_DONE
  );
endinterface

// File: rtl/ccd_conv3x3_stream_filter.sv
// 3x3 neighbourhood filter on the CCD pixel stream:
// pass, gray, Sobel magnitude or Gaussian, zero-padded borders.
module ccd_conv3x3_stream_filter #(
  parameter int IMG_WIDTH  = 800,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 10,
  parameter int CHANNELS   = 3
) (
  input logic CCD_FIFO_WRCLK,
  input logic RESET_N,
  ccd_conv3x3_stream_filter_if.slave px
);
  localparam int DW = CHANNELS * PIX_W;
  localparam int KW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int FW = $clog2(IMG_WIDTH + 2);
  localparam int SW = PIX_W + 4;
  localparam int GW = PIX_W + $clog2(CHANNELS) + 1;
  localparam logic [KW-1:0] XMAX = KW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] FILL = FW'(IMG_WIDTH + 1);
  localparam logic [FW-1:0] FEND = FW'(IMG_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t r_state, w_next;

  logic [KW-1:0] r_kx, r_px, r_cx;
  logic [YW-1:0] r_iy, r_py, r_cy;
  logic [FW-1:0] r_fcnt, r_fill;
  logic [1:0]    r_mode;
  logic          r_wv, r_wlast;

  logic          w_ready, w_acc, w_adv;
  logic          w_last_in, w_fdone, w_wv;
  logic [DW-1:0] w_din;

  logic [DW-1:0] r_lb0 [IMG_WIDTH];
  logic [DW-1:0] r_lb1 [IMG_WIDTH];
  logic [DW-1:0] r_win [3][3];

  assign w_ready   = (r_state != S_FLUSH);
  assign w_acc     = px.iDVAL && w_ready;
  assign w_adv     = w_acc || (r_state == S_FLUSH);
  assign w_din     = w_acc ? px.iDATA : '0;
  assign w_last_in = (r_kx == XMAX) && (r_iy == YMAX);
  assign w_fdone   = (r_state == S_FLUSH) && (r_fcnt == FEND);
  assign w_wv      = w_adv && (r_fill == FILL);

  always_ff @(posedge CCD_FIFO_WRCLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_acc) w_next = S_RUN;
      S_RUN:   if (w_acc && w_last_in) w_next = S_FLUSH;
      S_FLUSH: if (w_fdone) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CCD_FIFO_WRCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_kx    <= '0;
      r_iy    <= '0;
      r_fcnt  <= '0;
      r_fill  <= '0;
      r_mode  <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_wv    <= 1'b0;
      r_wlast <= 1'b0;
    end else begin
      if (w_adv)
        r_kx <= (w_fdone || r_kx == XMAX) ? '0 : r_kx + 1'b1;
      if (w_acc && r_kx == XMAX)
        r_iy <= (r_iy == YMAX) ? '0 : r_iy + 1'b1;
      if (r_state == S_FLUSH)
        r_fcnt <= w_fdone ? '0 : r_fcnt + 1'b1;
      if (w_fdone)
        r_fill <= '0;
      else if (w_adv && r_fill != FILL)
        r_fill <= r_fill + 1'b1;
      if (r_state == S_IDLE && w_acc)
        r_mode <= px.iMODE;
      r_wv <= w_wv;
      // output position of the window centre, one per valid advance
      if (w_wv) begin
        r_cx    <= r_px;
        r_cy    <= r_py;
        r_wlast <= (r_px == XMAX) && (r_py == YMAX);
        r_px    <= (r_px == XMAX) ? '0 : r_px + 1'b1;
        if (r_px == XMAX)
          r_py <= (r_py == YMAX) ? '0 : r_py + 1'b1;
      end
    end
  end

  always_ff @(posedge CCD_FIFO_WRCLK) begin
    if (w_adv) begin
      r_lb1[r_kx] <= w_din;
      r_lb0[r_kx] <= r_lb1[r_kx];
    end
  end

  always_ff @(posedge CCD_FIFO_WRCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_win[r][c] <= '0;
    end else if (w_adv) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= r_lb0[r_kx];
      r_win[1][2] <= r_lb1[r_kx];
      r_win[2][2] <= w_din;
    end
  end

  logic [2:0]    w_rok, w_cok;
  logic [DW-1:0] w_tap [9];

  assign w_rok = {r_cy != YMAX, 1'b1, r_cy != '0};
  assign w_cok = {r_cx != XMAX, 1'b1, r_cx != '0};

  // out-of-frame taps read zero whatever the line buffers hold
  always_comb begin
    for (int i = 0; i < 9; i++) w_tap[i] = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (w_rok[r] && w_cok[c])
          w_tap[r*3+c] = r_win[r][c];
  end

  function automatic logic [PIX_W-1:0] f_gray(
    input logic [DW-1:0] p
  );
    logic [GW-1:0] s;
    s = '0;
    for (int k = 0; k < CHANNELS; k++)
      s = s + GW'(p[k*PIX_W +: PIX_W]);
    return PIX_W'(s / GW'(CHANNELS));
  endfunction

  function automatic logic signed [SW-1:0] f_sx(
    input logic [PIX_W-1:0] g
  );
    return $signed(SW'(g));
  endfunction

  logic [DW-1:0] w_gauss;
  logic [SW-1:0] w_gs;

  always_comb begin
    w_gauss = '0;
    w_gs    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_gs = '0;
      for (int i = 0; i < 9; i++)
        w_gs = w_gs + (SW'(w_tap[i][k*PIX_W +: PIX_W])
               << ((i == 4) ? 2 : (i % 2)));
      w_gauss[k*PIX_W +: PIX_W] = w_gs[SW-1:4];
    end
  end

  logic             r_s1v, r_s1last;
  logic [1:0]       r_s1mode;
  logic [DW-1:0]    r_s1c, r_s1gau;
  logic [PIX_W-1:0] r_s1g [9];

  always_ff @(posedge CCD_FIFO_WRCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s1v    <= 1'b0;
      r_s1last <= 1'b0;
      r_s1mode <= '0;
      r_s1c    <= '0;
      r_s1gau  <= '0;
      for (int i = 0; i < 9; i++) r_s1g[i] <= '0;
    end else begin
      r_s1v    <= r_wv;
      r_s1last <= r_wv && r_wlast;
      if (r_wv) begin
        r_s1mode <= r_mode;
        r_s1c    <= r_win[1][1];
        r_s1gau  <= w_gauss;
        for (int i = 0; i < 9; i++) r_s1g[i] <= f_gray(w_tap[i]);
      end
    end
  end

  logic signed [SW-1:0] w_gx, w_gy;
  logic [SW-1:0]        w_ax, w_ay;
  logic [SW:0]          w_mag;
  logic [PIX_W-1:0]     w_sob;
  logic [DW-1:0]        w_res;

  always_comb begin
    w_gx = (f_sx(r_s1g[2]) + f_sx(r_s1g[5]) + f_sx(r_s1g[5])
           + f_sx(r_s1g[8]))
         - (f_sx(r_s1g[0]) + f_sx(r_s1g[3]) + f_sx(r_s1g[3])
           + f_sx(r_s1g[6]));
    w_gy = (f_sx(r_s1g[0]) + f_sx(r_s1g[1]) + f_sx(r_s1g[1])
           + f_sx(r_s1g[2]))
         - (f_sx(r_s1g[6]) + f_sx(r_s1g[7]) + f_sx(r_s1g[7])
           + f_sx(r_s1g[8]));
    w_ax  = w_gx[SW-1] ? SW'(-w_gx) : SW'(w_gx);
    w_ay  = w_gy[SW-1] ? SW'(-w_gy) : SW'(w_gy);
    w_mag = {1'b0, w_ax} + {1'b0, w_ay};
    w_sob = (|w_mag[SW:PIX_W]) ? '1 : w_mag[PIX_W-1:0];
    w_res = '0;
    unique case (r_s1mode)
      2'd0:    w_res = r_s1c;
      2'd1:    w_res = {CHANNELS{r_s1g[4]}};
      2'd2:    w_res = {CHANNELS{w_sob}};
      default: w_res = r_s1gau;
    endcase
  end

  logic          r_odv, r_ofd;
  logic [DW-1:0] r_odata;

  always_ff @(posedge CCD_FIFO_WRCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_odv   <= 1'b0;
      r_ofd   <= 1'b0;
      r_odata <= '0;
    end else begin
      r_odv <= r_s1v;
      r_ofd <= r_s1last;
      if (r_s1v) r_odata <= w_res;
    end
  end

  assign px.oREADY      = w_ready;
  assign px.oDVAL       = r_odv;
  assign px.oDATA       = r_odata;
  assign px.oFRAME_DONE = r_ofd;
endmodule

// File: tb/tb_ccd_conv3x3_stream_filter.sv
// Bench for ccd_conv3x3_stream_filter on an 8x4 frame.
// Spot vectors, latency/flush sequences and a raster model.
module tb_ccd_conv3x3_stream_filter;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 30;
  localparam int N  = W * H;

  localparam int P_RAMP = 0;
  localparam int P_FLAT = 1;
  localparam int P_STEP = 2;
  localparam int P_RGB  = 3;
  localparam int P_RAND = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  ccd_conv3x3_stream_filter_if #(.DW(DW)) bus ();

  ccd_conv3x3_stream_filter #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PIX_W     (10),
    .CHANNELS  (3)
  ) dut (
    .CCD_FIFO_WRCLK(clk),
    .RESET_N       (rst_n),
    .px            (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] oq[$];
  logic          fq[$];
  int            ocq[$];
  int            fdq[$];
  int            acc_cyc[$];

  always @(negedge clk) begin
    if (bus.oDVAL) begin
      oq.push_back(bus.oDATA);
      fq.push_back(bus.oFRAME_DONE);
      ocq.push_back(cyc);
    end
    if (bus.oFRAME_DONE) fdq.push_back(cyc);
  end

  logic [DW-1:0] fr [2][N];

  typedef struct {
    int mode;
    int pat;
    int x;
    int y;
    int exp;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] tap(int s, int x, int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return '0;
    return fr[s][y*W+x];
  endfunction

  function automatic int gry(logic [DW-1:0] p);
    return (int'(p[9:0]) + int'(p[19:10]) + int'(p[29:20])) / 3;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [DW-1:0] model(int s, int mode,
                                          int x, int y);
    logic [9:0]    v;
    logic [DW-1:0] p, r;
    int gx, gy, g, m, sum;
    r = '0;
    case (mode)
      0: r = tap(s, x, y);
      1: begin
        v = 10'(gry(tap(s, x, y)));
        r = {3{v}};
      end
      2: begin
        gx = 0;
        gy = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            g  = gry(tap(s, x + dx, y + dy));
            gx += dx * (2 - iabs(dy)) * g;
            gy -= dy * (2 - iabs(dx)) * g;
          end
        m = iabs(gx) + iabs(gy);
        if (m > 1023) m = 1023;
        v = 10'(m);
        r = {3{v}};
      end
      default: begin
        for (int k = 0; k < 3; k++) begin
          sum = 0;
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
              p = tap(s, x + dx, y + dy);
              sum += (2 - iabs(dx)) * (2 - iabs(dy))
                     * int'(p[k*10 +: 10]);
            end
          r[k*10 +: 10] = 10'(sum / 16);
        end
      end
    endcase
    return r;
  endfunction

  task automatic fill(input int s, input int pat);
    logic [9:0] v;
    for (int i = 0; i < N; i++) begin
      case (pat)
        P_RAMP: begin v = 10'(i); fr[s][i] = {3{v}}; end
        P_FLAT: fr[s][i] = {3{10'd100}};
        P_STEP: fr[s][i] = ((i % W) < 4) ? '0 : {3{10'd1023}};
        P_RGB:  fr[s][i] = {10'd90, 10'd60, 10'd30};
        default: fr[s][i] = DW'($urandom);
      endcase
    end
  endtask

  task automatic clear_q();
    oq.delete();
    fq.delete();
    ocq.delete();
    fdq.delete();
    acc_cyc.delete();
  endtask

  task automatic send_px(input logic [DW-1:0] d, input int duty);
    int t;
    t = 0;
    while (duty < 100 && $urandom_range(99) >= duty && t < 40) begin
      bus.iDVAL = 1'b0;
      @(posedge clk); #1;
      t++;
    end
    bus.iDVAL = 1'b1;
    bus.iDATA = d;
    t = 0;
    while (!bus.oREADY && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    acc_cyc.push_back(cyc);
  endtask

  task automatic send_frame(input int s, input int mode, input int duty,
                            input int sw_at, input int sw_mode);
    bus.iMODE = 2'(mode);
    for (int i = 0; i < N; i++) begin
      if (i == sw_at) bus.iMODE = 2'(sw_mode);
      send_px(fr[s][i], duty);
    end
  endtask

  task automatic wait_out(input int n, input string nm);
    int t;
    t = 0;
    while (oq.size() < n && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk(nm, 64'(oq.size()), 64'(n));
  endtask

  task automatic cmp_frame(input int s, input int mode, input int base,
                           input string nm);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_px%0d", nm, i), 64'(oq[base+i]),
          64'(model(s, mode, i % W, i / W)));
      chk($sformatf("%s_fd%0d", nm, i), 64'(fq[base+i]),
          64'(i == N - 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo;
    logic [9:0] e;
    tbl[0] = '{3, P_FLAT, 0, 0, 56};
    tbl[1] = '{3, P_FLAT, 1, 0, 75};
    tbl[2] = '{3, P_FLAT, 7, 3, 56};
    tbl[3] = '{3, P_FLAT, 3, 1, 100};
    tbl[4] = '{2, P_STEP, 3, 1, 1023};
    tbl[5] = '{2, P_STEP, 4, 2, 1023};
    tbl[6] = '{2, P_STEP, 1, 1, 0};
    tbl[7] = '{2, P_STEP, 7, 1, 1023};
    tbl[8] = '{1, P_RGB, 5, 2, 60};
    tbl[9] = '{0, P_RAMP, 6, 3, 30};

    bus.iDVAL = 1'b0;
    bus.iDATA = '0;
    bus.iMODE = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oready", 64'(bus.oREADY), 64'd1);
    chk("rst_odval", 64'(bus.oDVAL), 64'd0);
    chk("rst_odata", 64'(bus.oDATA), 64'd0);
    chk("rst_fdone", 64'(bus.oFRAME_DONE), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill(0, P_RAMP);
    clear_q();
    send_frame(0, 0, 100, -1, 0);
    bus.iDVAL = 1'b0;
    lo = 0;
    while (!bus.oREADY && lo < 50) begin
      @(posedge clk); #1;
      lo++;
    end
    chk("flush_ready_low", 64'(lo), 64'(W + 1));
    wait_out(N, "t1_count");
    chk("t1_latency", 64'(ocq[0] - acc_cyc[W+1]), 64'd2);
    cmp_frame(0, 0, 0, "t1");
    chk("t1_fd_count", 64'(fdq.size()), 64'd1);

    for (int i = 0; i < 10; i++) begin
      fill(0, tbl[i].pat);
      clear_q();
      send_frame(0, tbl[i].mode, 100, -1, 0);
      bus.iDVAL = 1'b0;
      wait_out(N, $sformatf("tbl%0d_count", i));
      e = 10'(tbl[i].exp);
      chk($sformatf("tbl%0d_m%0d_x%0d_y%0d", i, tbl[i].mode,
                    tbl[i].x, tbl[i].y),
          64'(oq[tbl[i].y*W+tbl[i].x]), 64'({3{e}}));
    end

    fill(0, P_RGB);
    clear_q();
    send_frame(0, 1, 30, -1, 0);
    bus.iDVAL = 1'b0;
    wait_out(N, "gaps_count");
    cmp_frame(0, 1, 0, "gaps");

    for (int f = 0; f < 3; f++) begin
      fill(0, P_RAND);
      clear_q();
      send_frame(0, f + 1, 40 + 30 * f, -1, 0);
      bus.iDVAL = 1'b0;
      wait_out(N, $sformatf("rnd%0d_count", f));
      cmp_frame(0, f + 1, 0, $sformatf("rnd%0d", f));
    end

    fill(0, P_RAMP);
    clear_q();
    bus.iMODE = 2'd0;
    for (int i = 0; i < 13; i++) send_px(fr[0][i], 100);
    bus.iDVAL = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_odval", 64'(bus.oDVAL), 64'd0);
    chk("mid_rst_odata", 64'(bus.oDATA), 64'd0);
    chk("mid_rst_fdone", 64'(bus.oFRAME_DONE), 64'd0);
    chk("mid_rst_oready", 64'(bus.oREADY), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    send_frame(0, 0, 100, -1, 0);
    bus.iDVAL = 1'b0;
    wait_out(N, "post_rst_count");
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_total", 64'(oq.size()), 64'(N));
    chk("post_rst_fd", 64'(fdq.size()), 64'd1);
    cmp_frame(0, 0, 0, "post_rst");

    fill(0, P_RAND);
    fill(1, P_RAND);
    clear_q();
    send_frame(0, 3, 100, 10, 0);
    send_frame(1, 0, 100, -1, 0);
    bus.iDVAL = 1'b0;
    chk("b2b_restart_gap", 64'(acc_cyc[N] - acc_cyc[N-1]),
        64'(W + 2));
    wait_out(2 * N, "b2b_count");
    cmp_frame(0, 3, 0, "b2b_f0");
    cmp_frame(1, 0, N, "b2b_f1");
    chk("b2b_fd", 64'(fdq.size()), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
